// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine: FSM state encoding and
// algorithm-select values for the mode input.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_BIN = 1'b1;

endpackage

// File: rtl/gcd_step.sv
// Combinational single update step of either Euclid (subtractive) or Stein
// (binary) GCD, plus the termination decode for the current operand pair.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int K_W   = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [K_W-1:0]   k,
  input  logic             mode,
  output logic [WIDTH-1:0] x_next,
  output logic [WIDTH-1:0] y_next,
  output logic [K_W-1:0]   k_next,
  output logic             done,
  output logic             is_zero
);

  localparam logic [K_W-1:0] K_ONE = {{(K_W-1){1'b0}}, 1'b1};

  always_comb begin
    is_zero = (x == '0) || (y == '0);
    done    = is_zero || (x == y);
    x_next  = x;
    y_next  = y;
    k_next  = k;
    if (!done) begin
      if (mode == MODE_SUB) begin
        if (x > y) x_next = x - y;
        else       y_next = y - x;
      end else begin
        // Shared factors of two are counted in k and restored at the end.
        unique case ({x[0], y[0]})
          2'b00: begin
            x_next = x >> 1;
            y_next = y >> 1;
            k_next = k + K_ONE;
          end
          2'b01: x_next = x >> 1;
          2'b10: y_next = y >> 1;
          default: begin
            if (x > y) x_next = x - y;
            else       y_next = y - x;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// Iterative GCD engine with valid/ready handshakes; one update step per clock
// in CALC, result and step count held in DONE until the consumer accepts them.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              mode,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  gcd,
  output logic [ITER_W-1:0] iters
);

  localparam int K_W = $clog2(WIDTH + 1);
  localparam logic [ITER_W-1:0] ITER_ONE = {{(ITER_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic [K_W-1:0]     k_q, k_d;
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   gcd_q, gcd_d;
  logic [ITER_W-1:0]  iters_q, iters_d;

  logic [WIDTH-1:0]   step_x, step_y;
  logic [K_W-1:0]     step_k;
  logic               step_done, step_zero;
  logic [WIDTH-1:0]   result;

  gcd_step #(
    .WIDTH (WIDTH),
    .K_W   (K_W)
  ) u_step (
    .x       (x_q),
    .y       (y_q),
    .k       (k_q),
    .mode    (mode_q),
    .x_next  (step_x),
    .y_next  (step_y),
    .k_next  (step_k),
    .done    (step_done),
    .is_zero (step_zero)
  );

  // The shift cannot overflow: x<<k never exceeds the smaller original operand.
  always_comb begin
    if (step_zero)               result = x_q | y_q;
    else if (mode_q == MODE_BIN) result = x_q << k_q;
    else                         result = x_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = CALC;
      CALC: begin
        if (abort)          state_d = IDLE;
        else if (step_done) state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    gcd       = gcd_q;
    iters     = iters_q;
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    mode_d  = mode_q;
    gcd_d   = gcd_q;
    iters_d = iters_q;
    if (state_q == IDLE && in_valid) begin
      x_d     = a;
      y_d     = b;
      mode_d  = mode;
      k_d     = '0;
      iters_d = '0;
    end else if (state_q == CALC && !abort) begin
      if (step_done) begin
        gcd_d = result;
      end else begin
        x_d     = step_x;
        y_d     = step_y;
        k_d     = step_k;
        iters_d = (iters_q == '1) ? iters_q : iters_q + ITER_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      mode_q  <= MODE_SUB;
      gcd_q   <= '0;
      iters_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      gcd_q   <= gcd_d;
      iters_q <= iters_d;
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: stimulus pushes hand-computed results, a
// monitor pops and checks them whenever out_valid rises.
module tb_gcd_engine;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready;
  logic [9:0]  a, b;
  logic        mode, abort;
  logic        out_valid, out_ready;
  logic [9:0]  gcd;
  logic [15:0] iters;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, abort2;
  logic [9:0]  gcd2;
  logic [7:0]  iters2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int g;
    int it;
    int lat;
    int acc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic ov_prev = 1'b0;

  gcd_engine #(.WIDTH(10), .ITER_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gcd       (gcd),
    .iters     (iters)
  );

  gcd_engine #(.WIDTH(10), .ITER_W(8)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .abort     (abort2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .gcd       (gcd2),
    .iters     (iters2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one pop per DONE episode, on the first cycle out_valid is seen.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out_valid: got gcd=%0d iters=%0d with nothing expected", gcd, iters);
        end else begin
          e = sb.pop_front();
          check("gcd", 32'(gcd), e.g);
          check("iters", 32'(iters), e.it);
          check("latency", cyc - e.acc, e.lat);
          $display("result gcd=%0d iters=%0d latency=%0d", gcd, iters, cyc - e.acc);
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (in_ready && sb.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL timeout: got no completion expected return to idle");
      sb.delete();
    end
  endtask

  task automatic issue(input logic m, input int av, input int bv,
                       input int eg, input int eit, input int elat);
    exp_t x;
    @(negedge clk);
    a        = av[9:0];
    b        = bv[9:0];
    mode     = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x.g   = eg;
    x.it  = eit;
    x.lat = elat;
    x.acc = cyc;
    sb.push_back(x);
    $display("issue mode=%0d a=%0d b=%0d expect gcd=%0d iters=%0d latency=%0d",
             m, av, bv, eg, eit, elat);
  endtask

  task automatic run(input logic m, input int av, input int bv,
                     input int eg, input int eit, input int elat);
    issue(m, av, bv, eg, eit, elat);
    wait_idle();
  endtask

  initial begin
    logic seen;
    int   acc2;

    rst        = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    mode       = 1'b0;
    abort      = 1'b0;
    out_ready  = 1'b1;
    in_valid2  = 1'b0;
    out_ready2 = 1'b1;
    abort2     = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 1);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_gcd", 32'(gcd), 0);
    check("reset_iters", 32'(iters), 0);

    run(1'b0, 48, 18, 6, 4, 5);
    run(1'b1, 48, 18, 6, 6, 7);
    run(1'b0, 0, 37, 37, 0, 1);
    run(1'b1, 0, 37, 37, 0, 1);
    run(1'b0, 0, 0, 0, 0, 1);
    run(1'b1, 37, 0, 37, 0, 1);
    run(1'b0, 7, 7, 7, 0, 1);
    run(1'b0, 35, 14, 7, 3, 4);
    run(1'b1, 512, 256, 256, 9, 10);
    run(1'b0, 1023, 1, 1, 1022, 1023);

    // Stalled consumer: result must hold and new operands must be ignored.
    out_ready = 1'b0;
    issue(1'b0, 48, 18, 6, 4, 5);
    in_valid = 1'b1;
    a        = 10'd12;
    b        = 10'd8;
    seen     = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check("stall_reached_done", 32'(seen), 1);
    for (int i = 0; i < 10; i++) begin
      abort = (i % 3 == 1);
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 1);
      check("stall_in_ready", 32'(in_ready), 0);
      check("stall_gcd", 32'(gcd), 6);
      check("stall_iters", 32'(iters), 4);
    end
    abort     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 1);
    check("release_out_valid", 32'(out_valid), 0);

    // Narrow counter saturates on the long subtractive run.
    @(negedge clk);
    a         = 10'd1023;
    b         = 10'd1;
    mode      = 1'b0;
    in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    acc2      = cyc;
    seen      = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid2;
    end
    check("sat_done", 32'(seen), 1);
    check("sat_latency", cyc - acc2, 1023);
    check("sat_gcd", 32'(gcd2), 1);
    check("sat_iters", 32'(iters2), 255);
    $display("result sat gcd=%0d iters=%0d latency=%0d", gcd2, iters2, cyc - acc2);
    @(negedge clk);
    check("sat_in_ready", 32'(in_ready2), 1);

    run(1'b1, 35, 14, 7, 4, 5);

    // Abort on the second edge after accept; one step has been taken by then.
    @(negedge clk);
    a        = 10'd100;
    b        = 10'd7;
    mode     = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 1);
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_gcd", 32'(gcd), 7);
    check("abort_iters", 32'(iters), 1);
    $display("abort in_ready=%0d gcd=%0d iters=%0d", in_ready, gcd, iters);
    repeat (3) @(negedge clk);
    run(1'b0, 12, 8, 4, 2, 3);

    // Reset in the middle of a long computation.
    @(negedge clk);
    a        = 10'd1023;
    b        = 10'd1;
    mode     = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_gcd", 32'(gcd), 0);
    check("rst_iters", 32'(iters), 0);
    $display("midreset in_ready=%0d gcd=%0d iters=%0d", in_ready, gcd, iters);
    repeat (3) @(negedge clk);
    run(1'b1, 12, 8, 4, 5, 6);

    repeat (20) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gcd_engine.md
GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 Parameter WIDTH, default 10, operand/result width in bits (>=2).
REQ-002 Parameter ITER_W, default 16, iteration-counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  operand pair and mode present.
REQ-006 in_ready  out  1  engine accepts operands; high only in IDLE.
REQ-007 a, b  in  WIDTH each  unsigned operands.
REQ-008 mode  in  1  0 = subtractive Euclid, 1 = binary (Stein).
REQ-009 abort  in  1  synchronous cancel of a computation in progress.
REQ-010 out_valid  out  1  result valid; held until consumed.
REQ-011 out_ready  in  1  consumer accepts result.
REQ-012 gcd  out  WIDTH  result, registered.
REQ-013 iters  out  ITER_W  update steps taken, registered, saturating.

Function
REQ-014 FSM states IDLE, CALC, DONE; each output is a registered value or a pure decode of state.
REQ-015 IDLE: in_ready=1; in_valid&&in_ready captures a->x, b->y, mode, clears k and iters, goes to CALC.
REQ-016 CALC, checks in priority order: abort -> IDLE, no out_valid, gcd/iters unchanged.
REQ-017 CALC, x==0 or y==0 -> DONE, gcd=x|y (gcd(0,0)=0), no update step counted.
REQ-018 CALC, x==y -> DONE, gcd=x (subtractive) or x<<k (binary).
REQ-019 Otherwise, subtractive: x>y -> x=x-y, else y=y-x; one step per clock.
REQ-020 Otherwise, binary: both even -> both >>1 and k+1; only x even -> x>>1; only y even -> y>>1; both odd -> larger=larger-smaller.
REQ-021 Each update step increments iters by 1, saturating at 2^ITER_W-1.
REQ-022 k width clog2(WIDTH+1); x<<k never exceeds WIDTH bits; result truncation impossible.
REQ-023 Latency: DONE entered N+1 edges after accepting edge, N = update steps; out_valid high from that edge.
REQ-024 DONE: out_valid=1, gcd/iters stable; out_valid&&out_ready -> IDLE same edge; in_ready low until IDLE (no overlap).
REQ-025 abort in IDLE or DONE is ignored.
REQ-026 Operands/mode changing while not in IDLE have no effect.

Reset
REQ-027 rst asserted: state=IDLE, x=y=0, k=0, gcd=0, iters=0, out_valid=0, in_ready=1 after reset release.
REQ-028 rst mid-CALC or mid-DONE discards the computation; no out_valid follows.

Structure
REQ-029 Shared package gcd_pkg holds state enum (IDLE, CALC, DONE) and mode constants MODE_SUB=0, MODE_BIN=1.
REQ-030 Sub-module gcd_step: combinational single-step update (x, y, k, mode -> next x, y, k, done, is_zero), instanced once.

Verification
REQ-031 mode=0, a=48, b=18 -> gcd=6, iters=4, out_valid 5 edges after accept.
REQ-032 mode=1, a=48, b=18 -> gcd=6, iters=6, out_valid 7 edges after accept.
REQ-033 a=0, b=37 (both modes), and a=0, b=0 -> gcd=37 / gcd=0, iters=0, out_valid 1 edge after accept.
REQ-034 mode=0, a=1023, b=1 -> gcd=1, iters=1022; repeat with ITER_W=8 -> iters=255 (saturated).
REQ-035 Hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> out_valid/gcd stable, in_ready=0, no new capture; out_ready=1 -> IDLE.
REQ-036 abort 2 cycles into mode=0 a=100, b=7, and separately rst mid-CALC -> IDLE, no out_valid; next pair 12,8 -> gcd=4.
